mma8452q_i2c_target: RTL and testbench

- I2C target (responder) that emulates the MMA8452Q register interface at 7-bit address 0x1D.
- Serves the same transactions the on-chip accelerometer reader issues: register-pointer write, data write, repeated-start or STOP-then-read, and burst read with auto-increment.
- Used as a bench/loopback model and as a board-level stand-in when the sensor is absent.
- Sensor samples are pushed in from fabric; the CTRL_REG1/CTRL_REG2 contents written over I2C are exported as outputs.

---
 rtl/mma8452q_i2c_target.sv | 229 ++++++++++++++++++++++
 tb/tb_mma8452q_i2c_target.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mma8452q_i2c_target.sv
// I2C target that emulates the MMA8452Q register interface.
// Ports:
//   clk, rst         - system clock (>= 16x SCL), async active-high reset
//   scl_in, sda_in   - raw bus lines, asynchronous to clk
//   sda_oe           - 1 pulls SDA low (open drain, never driven high)
//   smp_valid, smp_* - one-cycle strobe with signed 12-bit X/Y/Z samples
//   ctrl_reg1/2      - contents of registers 0x2A / 0x2B
//   busy             - high while the bus FSM is not IDLE
module mma8452q_i2c_target #(
  parameter logic [6:0] DEV_ADDR     = 7'h1D,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h2A
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scl_in,
  input  logic               sda_in,
  output logic               sda_oe,
  input  logic               smp_valid,
  input  logic signed [11:0] smp_x,
  input  logic signed [11:0] smp_y,
  input  logic signed [11:0] smp_z,
  output logic [7:0]         ctrl_reg1,
  output logic [7:0]         ctrl_reg2,
  output logic               busy
);

  localparam int unsigned NREG = 64;
  localparam int unsigned SW   = 12;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_IGNORE, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      sh_q, sh_d;
  logic [5:0]      ptr_q, ptr_d;
  logic            rw_q, rw_d, ack_ph_q, ack_ph_d;
  logic            sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic [7:0]      regs_q [NREG];
  logic [7:0]      regs_d [NREG];
  logic [SW-1:0]   stg_x_q, stg_x_d, stg_y_q, stg_y_d, stg_z_q, stg_z_d;
  logic            pend_q, pend_d;

  // Synchronised levels ([1]) and one-cycle history ([2]) for edge detection
  logic scl_rise_c, scl_fall_c, start_c, stop_c, sda_c, last_bit_c;
  logic [7:0] byte_c;

  assign scl_sync_d = {scl_sync_q[1:0], scl_in};
  assign sda_sync_d = {sda_sync_q[1:0], sda_in};
  assign sda_c      = sda_sync_q[1];
  assign scl_rise_c = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall_c = ~scl_sync_q[1] & scl_sync_q[2];
  assign start_c    = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_c;
  assign stop_c     = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_c;
  assign byte_c     = {sh_q[6:0], sda_c};
  assign last_bit_c = (bit_cnt_q == 3'd7);

  // Bus FSM, register file and sample staging
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    ack_ph_d  = ack_ph_q;
    sda_oe_d  = sda_oe_q;
    regs_d    = regs_q;
    stg_x_d   = stg_x_q;
    stg_y_d   = stg_y_q;
    stg_z_d   = stg_z_q;
    pend_d    = pend_q;

    if (start_c) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd0;
      ack_ph_d  = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_c) begin
      state_d   = S_IDLE;
      bit_cnt_d = 3'd0;
      ack_ph_d  = 1'b0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR, S_PTR, S_WR_DATA: begin
          if (scl_rise_c) begin
            sh_d      = byte_c;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit_c) begin
              if (state_q == S_ADDR) begin
                rw_d    = byte_c[0];
                state_d = (byte_c[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
              end else if (state_q == S_PTR) begin
                ptr_d   = byte_c[5:0];
                state_d = S_PTR_ACK;
              end else begin
                // Status, sample and ID registers silently drop writes
                if (ptr_q > 6'h06 && ptr_q != 6'h0D) regs_d[ptr_q] = byte_c;
                ptr_d   = ptr_q + 6'd1;
                state_d = S_WR_ACK;
              end
            end
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
          // First SCL fall grabs SDA, the next one releases it
          if (scl_fall_c) begin
            if (!ack_ph_q) begin
              sda_oe_d = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              ack_ph_d  = 1'b0;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                sh_d     = regs_q[ptr_q];
                sda_oe_d = ~regs_q[ptr_q][7];
                state_d  = S_RD_DATA;
              end else if (state_q == S_ADDR_ACK) begin
                state_d = S_PTR;
              end else begin
                state_d = S_WR_DATA;
              end
            end
          end
        end
        S_RD_DATA: begin
          if (scl_rise_c) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit_c) begin
              if (ptr_q == 6'h06) begin
                regs_d[0][7] = 1'b0;
                regs_d[0][3] = 1'b0;
              end
              ptr_d   = ptr_q + 6'd1;
              state_d = S_RD_ACK;
            end
          end else if (scl_fall_c && bit_cnt_q != 3'd0) begin
            sh_d     = {sh_q[6:0], 1'b0};
            sda_oe_d = ~sh_q[6];
          end
        end
        S_RD_ACK: begin
          if (scl_rise_c) begin
            if (sda_c) state_d = S_IGNORE;
            else       ack_ph_d = 1'b1;
          end else if (scl_fall_c) begin
            sda_oe_d = 1'b0;
            if (ack_ph_q) begin
              ack_ph_d  = 1'b0;
              bit_cnt_d = 3'd0;
              sh_d      = regs_q[ptr_q];
              sda_oe_d  = ~regs_q[ptr_q][7];
              state_d   = S_RD_DATA;
            end
          end
        end
        default: ;
      endcase
    end

    // Publish a staged sample only between transactions; copy beats clear
    if (pend_q && (state_q == S_IDLE || state_q == S_IGNORE)) begin
      regs_d[1]    = stg_x_q[11:4];
      regs_d[2]    = {stg_x_q[3:0], 4'h0};
      regs_d[3]    = stg_y_q[11:4];
      regs_d[4]    = {stg_y_q[3:0], 4'h0};
      regs_d[5]    = stg_z_q[11:4];
      regs_d[6]    = {stg_z_q[3:0], 4'h0};
      regs_d[0][3] = 1'b1;
      regs_d[0][7] = regs_q[0][7] | regs_q[0][3];
      pend_d       = 1'b0;
    end
    if (smp_valid) begin
      stg_x_d = $unsigned(smp_x);
      stg_y_d = $unsigned(smp_y);
      stg_z_d = $unsigned(smp_z);
      pend_d  = 1'b1;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      bit_cnt_q  <= 3'd0;
      sh_q       <= 8'h00;
      ptr_q      <= 6'd0;
      rw_q       <= 1'b0;
      ack_ph_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      stg_x_q    <= '0;
      stg_y_q    <= '0;
      stg_z_q    <= '0;
      pend_q     <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= (i == 13) ? WHO_AM_I_VAL : 8'h00;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      ack_ph_q   <= ack_ph_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      stg_x_q    <= stg_x_d;
      stg_y_q    <= stg_y_d;
      stg_z_q    <= stg_z_d;
      pend_q     <= pend_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign ctrl_reg1 = regs_q[42];
  assign ctrl_reg2 = regs_q[43];

endmodule

// File: tb/tb_mma8452q_i2c_target.sv
// Self-checking bench for mma8452q_i2c_target: bit-banged I2C host,
// a table of single-register write/read vectors, and hand-written sequences.
module tb_mma8452q_i2c_target;

  localparam int unsigned Q = 8;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic host_sda = 1'b1;
  logic sda_bus;
  logic sda_oe, busy;
  logic smp_valid = 1'b0;
  logic signed [11:0] smp_x = '0, smp_y = '0, smp_z = '0;
  logic [7:0] ctrl_reg1, ctrl_reg2;

  int vec_cnt = 0;
  int miss_cnt = 0;
  logic oe_acc;

  assign sda_bus = host_sda & ~sda_oe;

  always #5 clk = ~clk;

  mma8452q_i2c_target dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .smp_valid(smp_valid), .smp_x(smp_x), .smp_y(smp_y), .smp_z(smp_z),
    .ctrl_reg1(ctrl_reg1), .ctrl_reg2(ctrl_reg2), .busy(busy)
  );

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_BAD} op_t;
  typedef struct {
    op_t        op;
    logic [5:0] ra;
    logic [7:0] data;  // write data or expected read data
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic r);
    host_sda = b;
    wait_q();
    scl = 1'b1;
    wait_q();
    r = sda_bus;
    oe_acc = oe_acc | sda_oe;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    host_sda = 1'b1; wait_q();
    scl = 1'b1;      wait_q();
    host_sda = 1'b0; wait_q();
    scl = 1'b0;      wait_q();
  endtask

  task automatic i2c_stop();
    host_sda = 1'b0; wait_q();
    scl = 1'b1;      wait_q();
    host_sda = 1'b1; wait_q();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(d[i], r);
    bit_io(1'b1, ack);
  endtask

  task automatic rd_byte(input logic last, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(last, r);
  endtask

  // Pointer write, repeated START, then one byte read with NACK
  task automatic read_reg(input logic [5:0] ra, output logic [7:0] d, output logic [2:0] acks);
    i2c_start();
    wr_byte(8'h3A, acks[2]);
    wr_byte({2'b00, ra}, acks[1]);
    i2c_start();
    wr_byte(8'h3B, acks[0]);
    rd_byte(1'b1, d);
    i2c_stop();
  endtask

  task automatic write_reg(input logic [7:0] addr_byte, input logic [5:0] ra,
                           input logic [7:0] wd, output logic [2:0] acks);
    i2c_start();
    wr_byte(addr_byte, acks[2]);
    wr_byte({2'b00, ra}, acks[1]);
    wr_byte(wd, acks[0]);
    i2c_stop();
  endtask

  task automatic pulse_smp(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    smp_x = x; smp_y = y; smp_z = z;
    smp_valid = 1'b1;
    @(negedge clk);
    smp_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic [2:0] acks;
    logic [3:0] acks4;
    logic [7:0] exp_burst [7];
    logic [7:0] exp_b2 [6];

    tbl[0] = '{OP_RD,  6'h0D, 8'h2A};
    tbl[1] = '{OP_RD,  6'h00, 8'h00};
    tbl[2] = '{OP_WR,  6'h10, 8'hA5};
    tbl[3] = '{OP_RD,  6'h10, 8'hA5};
    tbl[4] = '{OP_WR,  6'h05, 8'h77};
    tbl[5] = '{OP_RD,  6'h05, 8'h00};
    tbl[6] = '{OP_WR,  6'h2B, 8'h3C};
    tbl[7] = '{OP_RD,  6'h2B, 8'h3C};
    tbl[8] = '{OP_BAD, 6'h2A, 8'hFF};
    tbl[9] = '{OP_RD,  6'h2A, 8'h00};
    exp_burst = '{8'h08, 8'hAB, 8'hC0, 8'h12, 8'h30, 8'hFF, 8'hF0};
    exp_b2    = '{8'hAB, 8'hC0, 8'h12, 8'h30, 8'hFF, 8'hF0};
    oe_acc = 1'b0;

    repeat (4) @(negedge clk);
    #1;
    check("rst sda_oe", 32'(sda_oe), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ctrl", 32'({ctrl_reg1, ctrl_reg2}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_q();

    // Table-driven single-register vectors
    for (int i = 0; i < 10; i++) begin
      oe_acc = 1'b0;
      unique case (tbl[i].op)
        OP_WR: begin
          write_reg(8'h3A, tbl[i].ra, tbl[i].data, acks);
          check($sformatf("vec%0d wr acks", i), 32'(acks), 32'h0);
        end
        OP_RD: begin
          read_reg(tbl[i].ra, d, acks);
          check($sformatf("vec%0d rd acks", i), 32'(acks), 32'h0);
          check($sformatf("vec%0d rd data", i), 32'(d), 32'(tbl[i].data));
        end
        default: begin
          i2c_start();
          wr_byte(8'h38, acks[2]);
          check($sformatf("vec%0d bad addr ack", i), 32'(acks[2]), 32'd1);
          wr_byte({2'b00, tbl[i].ra}, acks[1]);
          wr_byte(tbl[i].data, acks[0]);
          i2c_stop();
          check($sformatf("vec%0d bad addr sda", i), 32'(oe_acc), 32'd0);
        end
      endcase
    end
    check("ctrl_reg2 after write", 32'(ctrl_reg2), 32'h3C);
    check("ctrl_reg1 after bad addr", 32'(ctrl_reg1), 32'h00);

    // CTRL_REG1/2 written in one burst, four ACK slots
    i2c_start();
    wr_byte(8'h3A, acks4[3]);
    wr_byte(8'h2A, acks4[2]);
    wr_byte(8'h01, acks4[1]);
    wr_byte(8'h00, acks4[0]);
    check("busy mid txn", 32'(busy), 32'd1);
    i2c_stop();
    wait_q();
    check("ctrl burst acks", 32'(acks4), 32'h0);
    check("ctrl_reg1", 32'(ctrl_reg1), 32'h01);
    check("ctrl_reg2", 32'(ctrl_reg2), 32'h00);
    check("busy after stop", 32'(busy), 32'd0);

    // Sample copy and 7-byte burst read from STATUS
    pulse_smp(12'hABC, 12'h123, 12'hFFF);
    i2c_start();
    wr_byte(8'h3A, acks[2]);
    wr_byte(8'h00, acks[1]);
    i2c_start();
    wr_byte(8'h3B, acks[0]);
    for (int i = 0; i < 7; i++) begin
      rd_byte(i == 6, d);
      check($sformatf("burst byte%0d", i), 32'(d), 32'(exp_burst[i]));
    end
    i2c_stop();
    read_reg(6'h00, d, acks);
    check("status after burst", 32'(d), 32'h00);

    // Overrun: two strobes without a read sets ZYXOW
    pulse_smp(12'h111, 12'h222, 12'h333);
    pulse_smp(12'hABC, 12'h123, 12'hFFF);
    read_reg(6'h00, d, acks);
    check("status overrun", 32'(d), 32'h88);

    // Strobe arriving mid-burst must not tear the in-flight data
    i2c_start();
    wr_byte(8'h3A, acks[2]);
    wr_byte(8'h01, acks[1]);
    i2c_start();
    wr_byte(8'h3B, acks[0]);
    for (int i = 0; i < 6; i++) begin
      rd_byte(i == 5, d);
      check($sformatf("burst2 byte%0d", i), 32'(d), 32'(exp_b2[i]));
      if (i == 1) pulse_smp(12'h000, 12'h000, 12'h000);
    end
    i2c_stop();
    read_reg(6'h00, d, acks);
    check("status after late copy", 32'(d), 32'h08);
    read_reg(6'h01, d, acks);
    check("x msb after late copy", 32'(d), 32'h00);

    // Pointer wrap 0x3F -> 0x00; 0x00 stays read-only
    i2c_start();
    wr_byte(8'h3A, acks4[3]);
    wr_byte(8'h3F, acks4[2]);
    wr_byte(8'h55, acks4[1]);
    wr_byte(8'h66, acks4[0]);
    i2c_stop();
    check("wrap acks", 32'(acks4), 32'h0);
    read_reg(6'h3F, d, acks);
    check("reg 0x3F", 32'(d), 32'h55);
    read_reg(6'h00, d, acks);
    check("status after wrap write", 32'(d), 32'h08);

    // Reset in the middle of a read byte while SDA is held low
    i2c_start();
    wr_byte(8'h3A, acks[2]);
    wr_byte(8'h2A, acks[1]);
    i2c_start();
    wr_byte(8'h3B, acks[0]);
    bit_io(1'b1, d[7]);
    bit_io(1'b1, d[6]);
    host_sda = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    check("pre-reset read bit5", 32'({d[7:6], sda_oe}), 32'b001);
    rst = 1'b1;
    #1;
    check("reset sda_oe", 32'(sda_oe), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset ctrl_reg1", 32'(ctrl_reg1), 32'h00);
    wait_q();
    rst = 1'b0;
    wait_q();
    read_reg(6'h0D, d, acks);
    check("who_am_i after reset", 32'({acks, d}), 32'h02A);
    read_reg(6'h10, d, acks);
    check("scratch after reset", 32'(d), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
